// File: rtl/mips32_boot_pkg.sv
// Shared types and constants for the MIPS32 boot loader: FSM states,
// error codes and the header field layout.
package mips32_boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_ZERO  = 2'd1;
  localparam logic [1:0] ERR_RANGE = 2'd2;
  localparam logic [1:0] ERR_CSUM  = 2'd3;

  localparam int CNT_LSB = 16;
  localparam int CNT_W   = 16;

  // States in which the loader is consuming stream beats.
  function automatic logic is_streaming(input state_t s);
    return (s == ST_HDR) || (s == ST_LOAD) || (s == ST_CSUM);
  endfunction

endpackage

// File: rtl/mips32_boot_loader_if.sv
// Image stream (valid/ready) and memory write port of the boot loader.
// The loader is the slave of the stream and drives the memory port.
interface mips32_boot_loader_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) ();

  logic              s_valid;
  logic [DATA_W-1:0] s_data;
  logic              s_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;

  modport master (
    output s_valid, s_data,
    input  s_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  s_valid, s_data,
    output s_ready, mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/mips32_boot_csum.sv
// XOR accumulator for the image checksum; clear has priority over enable.
module mips32_boot_csum #(
  parameter int W = 32
) (
  input  logic         clk1,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] din,
  output logic [W-1:0] acc
);

  logic [W-1:0] acc_q;
  logic [W-1:0] acc_d;

  always_comb begin
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = acc_q ^ din;
    end
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

  assign acc = acc_q;

endmodule

// File: rtl/mips32_boot_loader.sv
// Streams a checksummed program image into core memory and releases the
// core (PC = image base, halt cleared) only after the checksum verifies.
module mips32_boot_loader
  import mips32_boot_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 10,
  parameter int MEM_DEPTH = 1024
) (
  input  logic                 clk1,
  input  logic                 rst_n,
  input  logic                 start,
  mips32_boot_loader_if.slave  bus,
  output logic                 cpu_halted,
  output logic [ADDR_W-1:0]    cpu_pc_init,
  output logic                 boot_done,
  output logic                 boot_err,
  output logic [1:0]           err_code
);

  // Range check is done wide enough that base + count can never wrap.
  localparam int              SUM_W     = ADDR_W + 17;
  localparam logic [SUM_W-1:0] DEPTH_LIM = SUM_W'(MEM_DEPTH);

  state_t state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic              s_ready_q, s_ready_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic              cpu_halted_q, cpu_halted_d;
  logic [ADDR_W-1:0] cpu_pc_init_q, cpu_pc_init_d;
  logic              boot_done_q, boot_done_d;
  logic              boot_err_q, boot_err_d;
  logic [1:0]        err_code_q, err_code_d;

  logic              accept;
  logic              csum_clr;
  logic              csum_en;
  logic [DATA_W-1:0] csum_acc;
  logic [CNT_W-1:0]  hdr_cnt;
  logic [ADDR_W-1:0] hdr_base;
  logic [SUM_W-1:0]  hdr_end;
  logic [CNT_W-1:0]  idx_inc;

  assign accept   = bus.s_valid && s_ready_q;
  assign hdr_cnt  = bus.s_data[CNT_LSB +: CNT_W];
  assign hdr_base = bus.s_data[ADDR_W-1:0];
  assign hdr_end  = SUM_W'(hdr_base) + SUM_W'(hdr_cnt);
  assign idx_inc  = idx_q + CNT_W'(1);

  mips32_boot_csum #(.W(DATA_W)) u_csum (
    .clk1 (clk1),
    .rst_n(rst_n),
    .clr  (csum_clr),
    .en   (csum_en),
    .din  (bus.s_data),
    .acc  (csum_acc)
  );

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    idx_d         = idx_q;
    base_d        = base_q;
    mem_we_d      = 1'b0;
    mem_addr_d    = mem_addr_q;
    mem_wdata_d   = mem_wdata_q;
    cpu_pc_init_d = cpu_pc_init_q;
    err_code_d    = err_code_q;
    csum_clr      = 1'b0;
    csum_en       = 1'b0;

    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          state_d    = ST_HDR;
          err_code_d = ERR_NONE;
          csum_clr   = 1'b1;
        end
      end
      ST_HDR: begin
        if (accept) begin
          cnt_d   = hdr_cnt;
          base_d  = hdr_base;
          idx_d   = '0;
          csum_en = 1'b1;
          if (hdr_cnt == '0) begin
            state_d    = ST_ERR;
            err_code_d = ERR_ZERO;
          end else if (hdr_end > DEPTH_LIM) begin
            state_d    = ST_ERR;
            err_code_d = ERR_RANGE;
          end else begin
            state_d = ST_LOAD;
          end
        end
      end
      ST_LOAD: begin
        if (accept) begin
          mem_we_d    = 1'b1;
          mem_addr_d  = base_q + idx_q[ADDR_W-1:0];
          mem_wdata_d = bus.s_data;
          csum_en     = 1'b1;
          idx_d       = idx_inc;
          if (idx_inc == cnt_q) begin
            state_d = ST_CSUM;
          end
        end
      end
      ST_CSUM: begin
        if (accept) begin
          if (bus.s_data == csum_acc) begin
            state_d       = ST_DONE;
            cpu_pc_init_d = base_q;
          end else begin
            state_d    = ST_ERR;
            err_code_d = ERR_CSUM;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Status outputs are registered from the next state so they change
    // together with the state, one cycle after the deciding beat.
    s_ready_d    = is_streaming(state_d);
    boot_done_d  = (state_d == ST_DONE);
    boot_err_d   = (state_d == ST_ERR);
    cpu_halted_d = (state_d != ST_DONE);
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      base_q        <= '0;
      s_ready_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      mem_addr_q    <= '0;
      mem_wdata_q   <= '0;
      cpu_halted_q  <= 1'b1;
      cpu_pc_init_q <= '0;
      boot_done_q   <= 1'b0;
      boot_err_q    <= 1'b0;
      err_code_q    <= ERR_NONE;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      base_q        <= base_d;
      s_ready_q     <= s_ready_d;
      mem_we_q      <= mem_we_d;
      mem_addr_q    <= mem_addr_d;
      mem_wdata_q   <= mem_wdata_d;
      cpu_halted_q  <= cpu_halted_d;
      cpu_pc_init_q <= cpu_pc_init_d;
      boot_done_q   <= boot_done_d;
      boot_err_q    <= boot_err_d;
      err_code_q    <= err_code_d;
    end
  end

  assign bus.s_ready   = s_ready_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign cpu_halted    = cpu_halted_q;
  assign cpu_pc_init   = cpu_pc_init_q;
  assign boot_done     = boot_done_q;
  assign boot_err      = boot_err_q;
  assign err_code      = err_code_q;

endmodule
